// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM client command queue.
// Command bundle, queue FSM states and burst-length constant.
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 32;
    localparam int SDRAM_DATA_W = 32;

    localparam logic [7:0] LEN_SINGLE = 8'd0;

    typedef struct packed {
        logic [3:0]              we;
        logic [SDRAM_ADDR_W-1:0] addr;
        logic [SDRAM_DATA_W-1:0] data;
    } sdram_cmd_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } cmdq_state_e;

    function automatic logic cmd_is_read(input sdram_cmd_t c);
        return c.we == 4'b0000;
    endfunction

endpackage

// File: rtl/sdram_core_if.sv
// Command/response channel between the client queue and the SDRAM core.
// man drives commands; sub answers with accept/ack.
interface sdram_core_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic [3:0]            wr;
    logic                  rd;
    logic [7:0]            len;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  accept;
    logic                  ack;
    logic                  error;
    logic [DATA_WIDTH-1:0] read_data;

    modport man (
        output wr, rd, len, addr, write_data,
        input  accept, ack, error, read_data
    );

    modport sub (
        input  wr, rd, len, addr, write_data,
        output accept, ack, error, read_data
    );

endinterface

// File: rtl/sdram_sync_fifo.sv
// Generic single-clock FIFO with registered occupancy.
// Head entry is presented combinationally on o_rdata.
module sdram_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == L_DEPTH);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap by overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_cmd_queue.sv
// Request queue in front of the SDRAM core with in-flight credit limit.
// Optional SDRAM_CMDQ_STATS_EN adds read/write/error counters.
module sdram_cmd_queue
    import sdram_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int MAX_OUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_error,
    output logic                  proto_err,
`ifdef SDRAM_CMDQ_STATS_EN
    output logic [31:0]           stat_rd,
    output logic [31:0]           stat_wr,
    output logic [31:0]           stat_err,
`endif
    sdram_core_if.man             core
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam logic [OW:0] L_MAX = (OW+1)'(MAX_OUT);

    cmdq_state_e     r_state;
    cmdq_state_e     w_state_nx;
    sdram_cmd_t      r_cmd;
    sdram_cmd_t      w_head;
    sdram_cmd_t      w_push_cmd;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic [OW-1:0]   r_out;
    logic [OW:0]     w_out_p1;
    logic            w_credit;
    logic            w_credit_after;
    logic            w_acc;
    logic            w_ack_dec;
    logic            w_issue;

    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_error;
    logic                  r_proto_err;

    assign w_push_cmd = '{we: req_we, addr: req_addr, data: req_wdata};

    sdram_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(sdram_cmd_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (req_valid && !w_full),
        .i_wdata (w_push_cmd),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign req_ready = !w_full;

    assign w_issue        = (r_state == ISSUE);
    assign w_acc          = w_issue && core.accept;
    assign w_ack_dec      = core.ack && (r_out != '0);
    assign w_out_p1       = {1'b0, r_out} + 1'b1;
    assign w_credit       = ({1'b0, r_out} < L_MAX);
    assign w_credit_after = (w_out_p1 < L_MAX);

    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty && w_credit) begin
                    w_pop      = 1'b1;
                    w_state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (core.accept) begin
                    if (!w_empty && w_credit_after) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd <= '0;
        end else if (w_pop) begin
            r_cmd <= w_head;
        end
    end

    // A stray ack at zero must not underflow the credit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            unique case ({w_acc, w_ack_dec})
                2'b10:   r_out <= r_out + 1'b1;
                2'b01:   r_out <= r_out - 1'b1;
                default: r_out <= r_out;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_rsp_valid <= core.ack;
            if (core.ack) begin
                r_rsp_data  <= core.read_data;
                r_rsp_error <= core.error;
            end
            if (core.ack && (r_out == '0)) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_error = r_rsp_error;
    assign proto_err = r_proto_err;

    assign core.wr         = w_issue ? r_cmd.we : 4'b0000;
    assign core.rd         = w_issue && cmd_is_read(r_cmd);
    assign core.len        = LEN_SINGLE;
    assign core.addr       = w_issue ? r_cmd.addr : '0;
    assign core.write_data = w_issue ? r_cmd.data : '0;

`ifdef SDRAM_CMDQ_STATS_EN
    logic [31:0] r_stat_rd;
    logic [31:0] r_stat_wr;
    logic [31:0] r_stat_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_rd  <= '0;
            r_stat_wr  <= '0;
            r_stat_err <= '0;
        end else begin
            if (w_acc && cmd_is_read(r_cmd)) begin
                r_stat_rd <= r_stat_rd + 1'b1;
            end
            if (w_acc && !cmd_is_read(r_cmd)) begin
                r_stat_wr <= r_stat_wr + 1'b1;
            end
            if (core.ack && core.error) begin
                r_stat_err <= r_stat_err + 1'b1;
            end
        end
    end

    assign stat_rd  = r_stat_rd;
    assign stat_wr  = r_stat_wr;
    assign stat_err = r_stat_err;
`endif

endmodule

// File: tb/tb_sdram_cmd_queue.sv
// Scoreboard bench for sdram_cmd_queue: default DUT plus a MAX_OUT=2 DUT.
// Commands and responses are checked in order against queued expectations.
module tb_sdram_cmd_queue;
    import sdram_pkg::*;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic        proto_err;

    logic        r2_valid;
    logic        r2_ready;
    logic [3:0]  r2_we;
    logic [31:0] r2_addr;
    logic [31:0] r2_wdata;
    logic        r2_rv;
    logic [31:0] r2_rd;
    logic        r2_re;
    logic        r2_pe;

`ifdef SDRAM_CMDQ_STATS_EN
    logic [31:0] s_rd, s_wr, s_err, s2_rd, s2_wr, s2_err;
`endif

    sdram_core_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) cif ();
    sdram_core_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) cif2 ();

    sdram_cmd_queue #(.DEPTH(4), .MAX_OUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_error (rsp_error),
        .proto_err (proto_err),
`ifdef SDRAM_CMDQ_STATS_EN
        .stat_rd   (s_rd),
        .stat_wr   (s_wr),
        .stat_err  (s_err),
`endif
        .core      (cif.man)
    );

    sdram_cmd_queue #(.DEPTH(4), .MAX_OUT(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (r2_valid),
        .req_ready (r2_ready),
        .req_we    (r2_we),
        .req_addr  (r2_addr),
        .req_wdata (r2_wdata),
        .rsp_valid (r2_rv),
        .rsp_data  (r2_rd),
        .rsp_error (r2_re),
        .proto_err (r2_pe),
`ifdef SDRAM_CMDQ_STATS_EN
        .stat_rd   (s2_rd),
        .stat_wr   (s2_wr),
        .stat_err  (s2_err),
`endif
        .core      (cif2.man)
    );

    sdram_cmd_t q_cmd[$];
    rsp_t       q_rsp[$];
    sdram_cmd_t me;
    rsp_t       mr;
    sdram_cmd_t cur;

    int n_chk = 0;
    int n_fail = 0;
    int n_acc = 0;
    int n_auto = 0;
    int n_acc2 = 0;
    int n_rsp = 0;

    logic        ack_req = 1'b0;
    logic        ack_auto = 1'b0;
    logic        ack_e = 1'b0;
    logic [31:0] ack_d = '0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic sdram_cmd_t mk(input int k);
        sdram_cmd_t c;
        case (k % 6)
            0:       c.we = 4'hF;
            1:       c.we = 4'h0;
            2:       c.we = 4'h3;
            3:       c.we = 4'h0;
            4:       c.we = 4'hC;
            default: c.we = 4'h1;
        endcase
        c.addr = 32'h1000 + 32'(k * 4);
        c.data = 32'hC0DE_0000 + 32'(k);
        return c;
    endfunction

    task automatic drive(input sdram_cmd_t c);
        req_we    = c.we;
        req_addr  = c.addr;
        req_wdata = c.data;
    endtask

    task automatic push1(input sdram_cmd_t c);
        drive(c);
        req_valid = 1'b1;
        chk("push_rdy", req_ready, 1);
        q_cmd.push_back(c);
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic ack1(input logic [31:0] d, input logic e);
        ack_d   = d;
        ack_e   = e;
        ack_req = 1'b1;
        cyc();
        ack_req = 1'b0;
    endtask

    // Core model: sole driver of the main DUT's ack/read_data/error.
    initial begin
        cif.ack       = 1'b0;
        cif.error     = 1'b0;
        cif.read_data = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!ack_auto) n_auto = n_acc;
            if (ack_req) begin
                cif.ack       = 1'b1;
                cif.read_data = ack_d;
                cif.error     = ack_e;
                q_rsp.push_back('{d: ack_d, e: ack_e});
            end else if (ack_auto && n_acc > n_auto) begin
                n_auto++;
                cif.ack       = 1'b1;
                cif.read_data = 32'hA000_0000 + 32'(n_auto);
                cif.error     = n_auto[0];
                q_rsp.push_back('{d: 32'hA000_0000 + 32'(n_auto),
                                  e: n_auto[0]});
            end else begin
                cif.ack       = 1'b0;
                cif.read_data = '0;
                cif.error     = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && cif.accept && (cif.wr != 4'h0 || cif.rd)) begin
            n_acc++;
            if (q_cmd.size() == 0) begin
                chk("cmd_extra", 1, 0);
            end else begin
                me = q_cmd.pop_front();
                chk("cmd_wr", cif.wr, me.we);
                chk("cmd_rd", cif.rd, me.we == 4'h0);
                chk("cmd_addr", cif.addr, me.addr);
                if (me.we != 4'h0) chk("cmd_wdata", cif.write_data, me.data);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            n_rsp++;
            if (q_rsp.size() == 0) begin
                chk("rsp_extra", 1, 0);
            end else begin
                mr = q_rsp.pop_front();
                chk("rsp_data", rsp_data, mr.d);
                chk("rsp_err", rsp_error, mr.e);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && cif2.accept && (cif2.wr != 4'h0 || cif2.rd)) n_acc2++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int cnt;
        int base;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
        r2_valid = 0; r2_we = 0; r2_addr = 0; r2_wdata = 0;
        cif.accept = 0;
        cif2.accept = 0; cif2.ack = 0; cif2.error = 0; cif2.read_data = 0;
        rst = 1;
        repeat (3) cyc();
        chk("rst_ready", req_ready, 1);
        chk("rst_wr", cif.wr, 0);
        chk("rst_rd", cif.rd, 0);
        chk("rst_addr", cif.addr, 0);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_rspd", rsp_data, 0);
        chk("rst_rspe", rsp_error, 0);
        chk("rst_perr", proto_err, 0);
        rst = 0;
        cyc();

        // Single write, immediate accept
        cif.accept = 1;
        push1('{we: 4'hF, addr: 32'h100, data: 32'hDEAD_BEEF});
        chk("lat_n1", cif.wr, 0);
        cyc();
        chk("lat_n2", cif.wr, 4'hF);
        chk("len0", cif.len, 0);
        cyc();
        chk("wr_once", cif.wr, 0);
        cif.accept = 0;
        cyc();
        cyc();
        ack1(32'h0, 1'b0);
        chk("wr_rspv", rsp_valid, 1);
        chk("wr_rspe", rsp_error, 0);
        cyc();
        chk("wr_rspv_end", rsp_valid, 0);

        // Read with accept withheld for 5 cycles
        push1('{we: 4'h0, addr: 32'h200, data: 32'h0});
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("hold_rd", cif.rd, 1);
            chk("hold_addr", cif.addr, 32'h200);
            cyc();
        end
        cif.accept = 1;
        cyc();
        cif.accept = 0;
        chk("rd_done", cif.rd, 0);
        ack1(32'h1234_5678, 1'b0);
        chk("rd_rspv", rsp_valid, 1);
        chk("rd_rspd", rsp_data, 32'h1234_5678);

        // Six requests, accept low until FIFO is full
        k = 0;
        cur = mk(0);
        drive(cur);
        req_valid = 1;
        for (int c = 0; c < 10; c++) begin
            if (req_valid && req_ready) begin
                q_cmd.push_back(cur);
                cyc();
                k++;
                cur = mk(k);
                drive(cur);
                if (k >= 6) req_valid = 0;
            end else begin
                cyc();
            end
        end
        chk("fill_cnt", k, 5);
        chk("fill_rdy", req_ready, 0);
        cif.accept = 1;
        ack_auto = 1;
        base = n_acc;
        cnt = 0;
        while ((n_acc - base) < 6 && cnt < 20) begin
            if (req_valid && req_ready) begin
                q_cmd.push_back(cur);
                cyc();
                req_valid = 0;
            end else begin
                cyc();
            end
            cnt++;
        end
        chk("b2b_cyc", cnt, 6);
        cif.accept = 0;
        for (int i = 0; i < 20 && n_auto < n_acc; i++) cyc();
        cyc();
        cyc();
        ack_auto = 0;
        chk("b2b_drain", dut.r_out, 0);

        // Credit limit on the MAX_OUT=2 instance
        cif2.accept = 1;
        for (int i = 0; i < 3; i++) begin
            r2_valid = 1;
            r2_we    = 4'hF;
            r2_addr  = 32'h40 * i;
            r2_wdata = 32'h5500 + i;
            cyc();
        end
        r2_valid = 0;
        repeat (6) cyc();
        chk("cred_n", n_acc2, 2);
        chk("cred_idle", cif2.wr, 0);
        cif2.ack = 1;
        cyc();
        cif2.ack = 0;
        chk("cred_wait", cif2.wr, 0);
        cyc();
        chk("cred_3rd", cif2.wr, 4'hF);
        chk("cred_addr", cif2.addr, 32'h80);
        cyc();
        chk("cred_n3", n_acc2, 3);
        cif2.accept = 0;

        // Simultaneous accept+ack, then a stray ack
        cif.accept = 1;
        push1(mk(20));
        cyc();
        cyc();
        cif.accept = 0;
        chk("sim_pre", dut.r_out, 1);
        push1(mk(21));
        cyc();
        cif.accept = 1;
        ack1(32'h0000_0011, 1'b0);
        cif.accept = 0;
        chk("sim_out", dut.r_out, 1);
        ack1(32'h0000_0022, 1'b1);
        chk("sim_zero", dut.r_out, 0);
        chk("perr_pre", proto_err, 0);
        ack1(32'h0000_0033, 1'b0);
        chk("stray_out", dut.r_out, 0);
        chk("stray_rspv", rsp_valid, 1);
        cyc();
        cyc();
        chk("perr_stick", proto_err, 1);

        // Reset with 3 queued and 1 outstanding
        cif.accept = 1;
        push1(mk(30));
        cyc();
        cyc();
        cif.accept = 0;
        for (int i = 0; i < 4; i++) push1(mk(31 + i));
        chk("pre_rst_out", dut.r_out, 1);
        rst = 1;
        cyc();
        chk("mrst_wr", cif.wr, 0);
        chk("mrst_rd", cif.rd, 0);
        chk("mrst_rdy", req_ready, 1);
        chk("mrst_rspv", rsp_valid, 0);
        q_cmd.delete();
        q_rsp.delete();
        cyc();
        rst = 0;
        chk("mrst_perr", proto_err, 0);

        // Recovery transaction
        cif.accept = 1;
        push1(mk(40));
        cyc();
        cyc();
        cif.accept = 0;
        ack1(32'hBEEF_0001, 1'b1);
        chk("rec_rspv", rsp_valid, 1);
        chk("rec_rspe", rsp_error, 1);
        repeat (3) cyc();

        chk("q_cmd_empty", q_cmd.size(), 0);
        chk("q_rsp_empty", q_rsp.size(), 0);
        chk("rsp_total", n_rsp, 12);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
